apb_cmp_timer: RTL and testbench
================================

// Module: apb_cmp_timer
// PURPOSE
//  Two-channel 32-bit compare/overflow timer, APB slave 3 of the peripheral subsystem.
//  Sits downstream of periph_bus_wrap on the timer_master port (PADDR[11:0]).
//  Drives the 4-bit timer_irq vector that feeds irq_i/event_i of apb_event_unit.
//  Clocked by the gated peripheral clock (clk_int[3]).
// PARAMETERS
//  APB_ADDR_WIDTH  12  width of PADDR seen by this slave
//  CNT_WIDTH       32  counter/compare width (must be <= 32, zero-extended on read)
//  PRESC_WIDTH     3   prescaler field width; tick period = 2^PRESC cycles
// PORTS
//  HCLK     in   1               clock
//  HRESETn  in   1               reset
//  PADDR    in   APB_ADDR_WIDTH  byte address; PADDR[4:2] selects register
//  PWDATA   in   32              write data
//  PWRITE   in   1               1 = write
//  PSEL     in   1               slave select
//  PENABLE  in   1               access phase
//  PRDATA   out  32              read data
//  PREADY   out  1               always 1 (zero wait states)
//  PSLVERR  out  1               error on unmapped offset
//  irq_o    out  4               {cmp1, ovf1, cmp0, ovf0}, single-cycle pulses
// BEHAVIOUR
//  One clock, HCLK. HRESETn is asynchronous, active-low.
//  Reset values: all registers 0, prescaler counters 0, irq_o=0, PRDATA=0, PSLVERR=0.
//  Register map (offset, access):
//   0x00 CNT0 RW | 0x04 CTRL0 RW | 0x08 CMP0 RW
//   0x10 CNT1 RW | 0x14 CTRL1 RW | 0x18 CMP1 RW
//   CTRLn: bit0 EN, bits[3+PRESC_WIDTH-1:3] PRESC. Other bits read 0.
//  APB handshake:
//   - A write commits on the edge where PSEL&PENABLE&PWRITE.
//   - PRDATA is combinational from PADDR while PSEL=1, else 0.
//   - Unmapped offsets (0x0C, 0x1C, >0x1F) give PSLVERR=1 during PSEL&PENABLE.
//     Such reads return 0 and writes are ignored.
//  Per channel n (independent):
//   - Prescaler counter pc_n increments each cycle while EN=1.
//   - tick_n = EN && pc_n == (2^PRESC-1); pc_n wraps to 0 on tick.
//     PRESC=0 gives a tick every cycle.
//   - On tick, if CNTn == CMPn: CNTn <= 0 and cmp_n fires.
//   - Otherwise, if CNTn == all-ones: CNTn <= 0 and ovf_n fires.
//   - Otherwise CNTn <= CNTn+1.
//   - Compare has priority over overflow when CMPn == all-ones: cmp fires, ovf does not.
//   - irq_o bits are registered: high for exactly one cycle, the cycle after the tick edge.
//   - EN=0: CNTn and pc_n hold, no irq.
//   - CMPn=0: the counter stays at 0 and cmp fires on every tick.
//  Simultaneous events:
//   - An APB write to CNTn in the same cycle as tick_n: the write wins and no irq is raised.
//   - Writing CNTn or CTRLn clears pc_n to 0.
//   - Writing CMPn does not disturb pc_n or CNTn.
//   - A new CMPn takes effect on the next tick.
//  Reset mid-operation: all state clears immediately (async).
//   Any irq pulse in flight is dropped.
//  Gated clock stopped: state frozen, no pulses. Resumes exactly on ungating.
// TESTING
//  1. Reset: HRESETn=0 mid-count -> irq_o=0, every register reads 0 and PSLVERR=0.
//  2. Write CMP0=4, CTRL0=0x1 -> CNT0 runs 0,1,2,3,4,0.
//     irq_o=4'b0010 one cycle after the 4->0 edge, repeating every 5 cycles.
//  3. Write CTRL1=0x11 (PRESC=2), CMP1=2 -> CNT1 steps every 4 cycles.
//     irq_o[3] pulses every 12 cycles.
//  4. Write CMP0=0xFFFF_FFFF, CNT0=0xFFFF_FFFE, EN=1 -> cmp0 pulses on wrap.
//     Then write CMP0=0x10, CNT0=0xFFFF_FFFF -> ovf0 (irq_o=4'b0001) pulses once.
//  5. CNT0 write 0x100 in the same cycle as a tick that matches CMP0 -> reads 0x100.
//     No irq pulse occurs; the next increment is 2^PRESC cycles later.
//  6. Read and write offset 0x0C -> PSLVERR=1, PRDATA=0, no register changes.
//     Both channels run concurrently with no cross-talk.

Source files
------------

// File: rtl/apb_cmp_timer_if.sv
// APB slave-side bus bundle for apb_cmp_timer.
// Ports: PADDR/PWDATA/PWRITE/PSEL/PENABLE in, PRDATA/PREADY/PSLVERR out.
interface apb_cmp_timer_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmp_timer.sv
// Two-channel compare/overflow timer with APB register access.
// Ports: HCLK, HRESETn (async active-low), apb (slave modport),
// irq_o = {cmp1, ovf1, cmp0, ovf0} single-cycle registered pulses.
module apb_cmp_timer #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH      = 32,
    parameter int PRESC_WIDTH    = 3
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    apb_cmp_timer_if.slave   apb,
    output logic [3:0]       irq_o
);
    // Prescaler counter wide enough for the largest 2^PRESC-1 terminal value.
    localparam int PCW = (1 << PRESC_WIDTH) - 1;

    logic [CNT_WIDTH-1:0]   r_cnt   [2];
    logic [CNT_WIDTH-1:0]   r_cmp   [2];
    logic                   r_en    [2];
    logic [PRESC_WIDTH-1:0] r_presc [2];
    logic [PCW-1:0]         r_pc    [2];
    logic [3:0]             r_irq;

    logic [2:0]  w_off;
    logic        w_ch;
    logic        w_mapped;
    logic        w_wr;
    logic [1:0]  w_wr_cnt;
    logic [1:0]  w_wr_ctrl;
    logic [1:0]  w_wr_cmp;
    logic [1:0]  w_tick;
    logic [PCW-1:0] w_lim [2];
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_off    = apb.PADDR[4:2];
    assign w_ch     = w_off[2];
    assign w_mapped = (apb.PADDR[APB_ADDR_WIDTH-1:5] == '0)
                   && (w_off[1:0] != 2'b11);
    assign w_wr     = apb.PSEL && apb.PENABLE && apb.PWRITE && w_mapped;
    assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA};

    always_comb begin
        w_wr_cnt  = '0;
        w_wr_ctrl = '0;
        w_wr_cmp  = '0;
        w_tick    = '0;
        for (int i = 0; i < 2; i++) begin
            // Low PRESC bits set: terminal count of the prescaler.
            w_lim[i]     = ~({PCW{1'b1}} << r_presc[i]);
            w_tick[i]    = r_en[i] && (r_pc[i] == w_lim[i]);
            w_wr_cnt[i]  = w_wr && (w_ch == i[0]) && (w_off[1:0] == 2'd0);
            w_wr_ctrl[i] = w_wr && (w_ch == i[0]) && (w_off[1:0] == 2'd1);
            w_wr_cmp[i]  = w_wr && (w_ch == i[0]) && (w_off[1:0] == 2'd2);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i]   <= '0;
                r_cmp[i]   <= '0;
                r_en[i]    <= 1'b0;
                r_presc[i] <= '0;
                r_pc[i]    <= '0;
            end
        end else begin
            r_irq <= '0;
            for (int i = 0; i < 2; i++) begin
                // A bus write to CNT overrides this cycle's tick entirely.
                if (w_wr_cnt[i]) begin
                    r_cnt[i] <= apb.PWDATA[CNT_WIDTH-1:0];
                end else if (w_tick[i]) begin
                    if (r_cnt[i] == r_cmp[i]) begin
                        r_cnt[i]     <= '0;
                        r_irq[2*i+1] <= 1'b1;
                    end else if (&r_cnt[i]) begin
                        r_cnt[i]   <= '0;
                        r_irq[2*i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end

                if (w_wr_cnt[i] || w_wr_ctrl[i]) begin
                    r_pc[i] <= '0;
                end else if (w_tick[i]) begin
                    r_pc[i] <= '0;
                end else if (r_en[i]) begin
                    r_pc[i] <= r_pc[i] + 1'b1;
                end

                if (w_wr_ctrl[i]) begin
                    r_en[i]    <= apb.PWDATA[0];
                    r_presc[i] <= apb.PWDATA[3 +: PRESC_WIDTH];
                end

                if (w_wr_cmp[i]) begin
                    r_cmp[i] <= apb.PWDATA[CNT_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (apb.PSEL && w_mapped) begin
            case (w_off[1:0])
                2'd0:    w_rdata = 32'(r_cnt[w_ch]);
                2'd1:    w_rdata = 32'({r_presc[w_ch], 2'b00, r_en[w_ch]});
                2'd2:    w_rdata = 32'(r_cmp[w_ch]);
                default: w_rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = w_rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL && apb.PENABLE && !w_mapped;
    assign irq_o       = r_irq;
endmodule

// File: tb/tb_apb_cmp_timer.sv
// Randomized self-checking bench for apb_cmp_timer.
// A behavioural register/counter model is checked every cycle.
module tb_apb_cmp_timer;
    logic       HCLK;
    logic       HRESETn;
    logic [3:0] irq_o;

    apb_cmp_timer_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_cmp_timer #(
        .APB_ADDR_WIDTH(12),
        .CNT_WIDTH(32),
        .PRESC_WIDTH(3)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .apb(bus),
        .irq_o(irq_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks;
    int failures;

    localparam longint unsigned MAXV = 64'hFFFF_FFFF;

    longint unsigned m_cnt [2];
    longint unsigned m_cmp [2];
    int              m_pc [2];
    int              m_presc [2];
    bit              m_en [2];
    logic [3:0]      m_irq;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        int ch;
        mread = '0;
        if (a < 12'h20 && a[3:2] != 2'b11) begin
            ch = int'(a[4]);
            case (a[3:2])
                2'd0: mread = 32'(m_cnt[ch]);
                2'd1: mread = 32'(m_presc[ch] * 8 + int'(m_en[ch]));
                2'd2: mread = 32'(m_cmp[ch]);
                default: mread = '0;
            endcase
        end
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0;
            m_cmp[c] = 0;
            m_pc[c] = 0;
            m_presc[c] = 0;
            m_en[c] = 0;
        end
        m_irq = 4'b0;
    endtask

    // One clock of the timer rules: counter value, period, events.
    task automatic model_step();
        bit acc;
        int off;
        int period;
        bit tick;
        bit wcnt;
        bit wctl;
        bit wcmp;
        logic [3:0] nirq;
        acc = bus.PSEL && bus.PENABLE && bus.PWRITE;
        off = int'(bus.PADDR);
        nirq = 4'b0;
        for (int c = 0; c < 2; c++) begin
            wcnt = acc && off == c * 16;
            wctl = acc && off == c * 16 + 4;
            wcmp = acc && off == c * 16 + 8;
            period = 1 << m_presc[c];
            tick = m_en[c] && ((m_pc[c] + 1) % period == 0);
            if (wcnt) begin
                m_cnt[c] = longint'(bus.PWDATA);
            end else if (tick) begin
                if (m_cnt[c] == m_cmp[c]) begin
                    m_cnt[c] = 0;
                    nirq[2*c+1] = 1'b1;
                end else if (m_cnt[c] == MAXV) begin
                    m_cnt[c] = 0;
                    nirq[2*c] = 1'b1;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (wcnt || wctl) m_pc[c] = 0;
            else if (m_en[c]) m_pc[c] = (m_pc[c] + 1) % period;
            if (wctl) begin
                m_en[c] = bus.PWDATA[0];
                m_presc[c] = int'(bus.PWDATA[5:3]);
            end
            if (wcmp) m_cmp[c] = longint'(bus.PWDATA);
        end
        m_irq = nirq;
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) model_clear();
        else model_step();
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            chk("irq", 32'(irq_o), 32'(m_irq));
            chk("pready", 32'(bus.PREADY), 32'd1);
            chk("pslverr", 32'(bus.PSLVERR),
                32'(bus.PSEL && bus.PENABLE &&
                    mread(bus.PADDR) == 0 &&
                    (bus.PADDR >= 12'h20 || bus.PADDR[3:2] == 2'b11)));
            chk("prdata", bus.PRDATA,
                bus.PSEL ? mread(bus.PADDR) : 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        bus.PADDR = a;
        bus.PWDATA = d;
        bus.PWRITE = 1'b1;
        bus.PSEL = 1'b1;
        bus.PENABLE = 1'b0;
        step(1);
        bus.PENABLE = 1'b1;
        step(1);
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                            output logic e);
        bus.PADDR = a;
        bus.PWRITE = 1'b0;
        bus.PSEL = 1'b1;
        bus.PENABLE = 1'b0;
        step(1);
        bus.PENABLE = 1'b1;
        #3;
        d = bus.PRDATA;
        e = bus.PSLVERR;
        step(1);
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic wait_irq(input logic [3:0] m, input int budget,
                            output int n);
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while ((irq_o & m) == 0 && n < budget);
        if ((irq_o & m) == 0) begin
            checks++;
            failures++;
            $display("FAIL irq_timeout got=%h exp_mask=%h", irq_o, m);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          gap;
    logic [11:0] ra;
    logic [31:0] rdat;
    int          sel;

    initial begin
        checks = 0;
        failures = 0;
        HRESETn = 1'b0;
        bus.PADDR = '0;
        bus.PWDATA = '0;
        bus.PWRITE = 1'b0;
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
        step(3);
        HRESETn = 1'b1;
        step(1);

        // Reset values
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) continue;
            apb_read(12'(k * 4), rd, er);
            chk("rst_reg", rd, 32'd0);
        end

        // Channel 0: CMP=4, period of 5 compare pulses
        apb_write(12'h008, 32'd4);
        apb_write(12'h004, 32'h1);
        wait_irq(4'b0011, 40, gap);
        chk("ch0_irq_code", 32'(irq_o), 32'h2);
        wait_irq(4'b0011, 40, gap);
        chk("ch0_gap", 32'(gap), 32'd5);
        wait_irq(4'b0011, 40, gap);
        chk("ch0_gap2", 32'(gap), 32'd5);
        step(1);

        // Channel 1: PRESC=2, CMP=2 -> 12-cycle period
        apb_write(12'h014, 32'h11);
        apb_write(12'h018, 32'd2);
        wait_irq(4'b1000, 80, gap);
        wait_irq(4'b1000, 80, gap);
        chk("ch1_gap", 32'(gap), 32'd12);
        wait_irq(4'b1000, 80, gap);
        chk("ch1_gap2", 32'(gap), 32'd12);
        step(1);

        // Compare beats overflow at all-ones, then plain overflow
        apb_write(12'h004, 32'h0);
        apb_write(12'h008, 32'hFFFF_FFFF);
        apb_write(12'h000, 32'hFFFF_FFFE);
        apb_write(12'h004, 32'h1);
        wait_irq(4'b0011, 20, gap);
        chk("cmp_at_max", 32'(irq_o[1:0]), 32'h2);
        step(1);
        apb_write(12'h008, 32'h10);
        apb_write(12'h000, 32'hFFFF_FFFF);
        wait_irq(4'b0011, 20, gap);
        chk("ovf", 32'(irq_o[1:0]), 32'h1);
        step(1);

        // CNT write collides with a matching tick
        apb_write(12'h004, 32'h0);
        apb_write(12'h008, 32'h0);
        apb_write(12'h004, 32'h1);
        step(3);
        apb_write(12'h000, 32'h100);
        chk("wr_wins_noirq", 32'(irq_o[1:0]), 32'h0);
        apb_read(12'h000, rd, er);
        chk("wr_wins_cnt", rd, 32'h101);

        // Unmapped offsets
        apb_read(12'h00C, rd, er);
        chk("unm_err", 32'(er), 32'd1);
        chk("unm_data", rd, 32'd0);
        apb_write(12'h00C, 32'hFFFF_FFFF);
        apb_read(12'h008, rd, er);
        chk("unm_noeffect", rd, 32'd0);
        apb_read(12'h024, rd, er);
        chk("hi_err", 32'(er), 32'd1);

        // Reset mid-count
        HRESETn = 1'b0;
        #2;
        chk("rst_irq", 32'(irq_o), 32'd0);
        step(1);
        apb_read(12'h010, rd, er);
        chk("rst_cnt1", rd, 32'd0);
        chk("rst_err", 32'(er), 32'd0);
        HRESETn = 1'b1;
        step(1);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                HRESETn = 1'b0;
                step(1);
                HRESETn = 1'b1;
                step(1);
            end
            sel = int'($urandom_range(0, 9));
            ra = (sel < 8) ? 12'(sel * 4) : 12'(32 + 4 * sel);
            if (sel == 0 || sel == 4) begin
                case ($urandom_range(0, 2))
                    0: rdat = $urandom_range(0, 12);
                    1: rdat = 32'hFFFF_FFFF - $urandom_range(0, 6);
                    default: rdat = $urandom;
                endcase
            end else if (sel == 1 || sel == 5) begin
                rdat = {$urandom_range(0, 3) == 0 ? 29'h7 :
                        29'($urandom_range(0, 2)),
                        2'($urandom),
                        1'($urandom_range(0, 4) != 0)};
            end else if (sel == 2 || sel == 6) begin
                rdat = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF
                     : 32'($urandom_range(0, 15));
            end else begin
                rdat = $urandom;
            end
            if ($urandom_range(0, 9) < 6) apb_write(ra, rdat);
            else apb_read(ra, rd, er);
            step(int'($urandom_range(0, 3)));
        end
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
